// File: rtl/vend_pkg.sv
// Shared types and lookups for the vending transaction sequencer.
package vend_pkg;

    localparam int unsigned CREDIT_W_DEF = 7;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_CREDIT = 2'd1,
        S_VEND   = 2'd2,
        S_CHANGE = 2'd3
    } state_e;

    localparam logic [4:0] COIN_1  = 5'd1;
    localparam logic [4:0] COIN_5  = 5'd5;
    localparam logic [4:0] COIN_10 = 5'd10;
    localparam logic [4:0] COIN_20 = 5'd20;

    // Only meaningful for a one-hot coin vector; anything else is worth nothing.
    function automatic logic [4:0] coin_value(input logic [3:0] ev);
        case (ev)
            4'b0001: coin_value = COIN_1;
            4'b0010: coin_value = COIN_5;
            4'b0100: coin_value = COIN_10;
            4'b1000: coin_value = COIN_20;
            default: coin_value = 5'd0;
        endcase
    endfunction

    function automatic int unsigned price_lookup(input logic [2:0] idx,
                                                 input int unsigned p0, input int unsigned p1,
                                                 input int unsigned p2, input int unsigned p3,
                                                 input int unsigned p4);
        case (idx)
            3'd0:    price_lookup = p0;
            3'd1:    price_lookup = p1;
            3'd2:    price_lookup = p2;
            3'd3:    price_lookup = p3;
            3'd4:    price_lookup = p4;
            default: price_lookup = 0;
        endcase
    endfunction

endpackage

// File: rtl/vend_txn_ctrl_rise_edge.sv
// Registered rising-edge detector: one-cycle event when the level goes 0 -> 1.
module rise_edge (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic rise_o
);
    logic d_q;

    always_ff @(posedge clk) begin
        if (!rst) d_q <= 1'b0;
        else      d_q <= d_i;
    end

    assign rise_o = d_i & ~d_q;
endmodule

// File: rtl/vend_txn_ctrl.sv
// Vending transaction sequencer: coin/button events, credit register,
// selection cursor and vend/change handshakes to the dispenser.
module vend_txn_ctrl
    import vend_pkg::*;
#(
    parameter int unsigned CREDIT_W    = CREDIT_W_DEF,
    parameter int unsigned MAX_CREDIT  = 99,
    parameter int unsigned N_ITEMS     = 5,
    parameter int unsigned PRICE0      = 7,
    parameter int unsigned PRICE1      = 5,
    parameter int unsigned PRICE2      = 6,
    parameter int unsigned PRICE3      = 10,
    parameter int unsigned PRICE4      = 8,
    parameter int unsigned TIMEOUT_CYC = 1_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          coin_in,
    input  logic                btn_l,
    input  logic                btn_r,
    input  logic                btn_c,
    input  logic                btn_refund,
    input  logic                vend_ready,
    input  logic                change_ready,
    output logic [CREDIT_W-1:0] credit,
    output logic [2:0]          sel_idx,
    output logic [CREDIT_W-1:0] sel_price,
    output logic [N_ITEMS-1:0]  avail,
    output logic                vend_valid,
    output logic [2:0]          vend_item,
    output logic                change_valid,
    output logic [CREDIT_W-1:0] change_amt,
    output logic                coin_reject,
    output logic                deny,
    output logic [1:0]          state_o
);
    localparam int unsigned     CNT_W   = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CREDIT_W:0] MAX_C  = (CREDIT_W + 1)'(MAX_CREDIT);
    localparam logic [2:0]      LAST_IDX = 3'(N_ITEMS - 1);

    state_e              state_q;
    logic [CREDIT_W-1:0] credit_q, change_amt_q;
    logic [2:0]          sel_idx_q, vend_item_q;
    logic [N_ITEMS-1:0]  avail_q, avail_d;
    logic                vend_valid_q, change_valid_q, coin_reject_q, deny_q;
    logic [CNT_W-1:0]    tmr_q;

    logic [3:0] coin_ev, btn_ev, btn_lvl;
    logic       ev_l, ev_r, ev_c, ev_ref;
    logic       coin_any, coin_one, coin_ok;
    logic [CREDIT_W:0] coin_sum;

    for (genvar i = 0; i < 4; i++) begin : g_edge
        rise_edge u_coin (.clk(clk), .rst(rst), .d_i(coin_in[i]), .rise_o(coin_ev[i]));
        rise_edge u_btn  (.clk(clk), .rst(rst), .d_i(btn_lvl[i]), .rise_o(btn_ev[i]));
    end

    assign btn_lvl = {btn_refund, btn_c, btn_r, btn_l};
    assign {ev_ref, ev_c, ev_r, ev_l} = btn_ev;

    // A coin is taken only if exactly one bit rose and the sum stays in range.
    assign coin_any = |coin_ev;
    assign coin_one = coin_any && ((coin_ev & (coin_ev - 4'd1)) == 4'd0);
    assign coin_sum = {1'b0, credit_q} + (CREDIT_W + 1)'(coin_value(coin_ev));
    assign coin_ok  = coin_one && (coin_sum <= MAX_C);

    assign sel_price = CREDIT_W'(price_lookup(sel_idx_q, PRICE0, PRICE1, PRICE2, PRICE3, PRICE4));

    for (genvar i = 0; i < N_ITEMS; i++) begin : g_avail
        assign avail_d[i] = credit_q >= CREDIT_W'(price_lookup(3'(i), PRICE0, PRICE1, PRICE2, PRICE3, PRICE4));
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q        <= S_IDLE;
            credit_q       <= '0;
            sel_idx_q      <= '0;
            avail_q        <= '0;
            vend_valid_q   <= 1'b0;
            vend_item_q    <= '0;
            change_valid_q <= 1'b0;
            change_amt_q   <= '0;
            coin_reject_q  <= 1'b0;
            deny_q         <= 1'b0;
            tmr_q          <= '0;
        end else begin
            coin_reject_q <= 1'b0;
            deny_q        <= 1'b0;
            avail_q       <= avail_d;
            case (state_q)
                S_IDLE: begin
                    if (coin_ok) begin
                        credit_q <= coin_sum[CREDIT_W-1:0];
                        tmr_q    <= '0;
                        state_q  <= S_CREDIT;
                    end else if (coin_any) begin
                        coin_reject_q <= 1'b1;
                    end
                end
                S_CREDIT: begin
                    tmr_q <= tmr_q + 1'b1;
                    // Refund (button or timeout) beats confirm, which beats coins, which beat the cursor.
                    if (ev_ref || tmr_q == TO_LAST) begin
                        coin_reject_q  <= coin_any;
                        change_amt_q   <= credit_q;
                        change_valid_q <= 1'b1;
                        state_q        <= S_CHANGE;
                    end else if (ev_c) begin
                        coin_reject_q <= coin_any;
                        if (credit_q >= sel_price) begin
                            credit_q     <= credit_q - sel_price;
                            vend_item_q  <= sel_idx_q;
                            vend_valid_q <= 1'b1;
                            state_q      <= S_VEND;
                        end else begin
                            deny_q <= 1'b1;
                        end
                    end else if (coin_any) begin
                        if (coin_ok) begin
                            credit_q <= coin_sum[CREDIT_W-1:0];
                            tmr_q    <= '0;
                        end else begin
                            coin_reject_q <= 1'b1;
                        end
                    end else if (ev_l ^ ev_r) begin
                        tmr_q <= '0;
                        if (ev_l) sel_idx_q <= (sel_idx_q == 3'd0) ? LAST_IDX : sel_idx_q - 3'd1;
                        else      sel_idx_q <= (sel_idx_q == LAST_IDX) ? 3'd0 : sel_idx_q + 3'd1;
                    end
                end
                S_VEND: begin
                    coin_reject_q <= coin_any;
                    if (vend_ready) begin
                        vend_valid_q <= 1'b0;
                        if (credit_q != '0) begin
                            change_amt_q   <= credit_q;
                            change_valid_q <= 1'b1;
                            state_q        <= S_CHANGE;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end
                end
                S_CHANGE: begin
                    coin_reject_q <= coin_any;
                    if (change_ready) begin
                        credit_q       <= '0;
                        change_valid_q <= 1'b0;
                        state_q        <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign credit       = credit_q;
    assign sel_idx      = sel_idx_q;
    assign avail        = avail_q;
    assign vend_valid   = vend_valid_q;
    assign vend_item    = vend_item_q;
    assign change_valid = change_valid_q;
    assign change_amt   = change_amt_q;
    assign coin_reject  = coin_reject_q;
    assign deny         = deny_q;
    assign state_o      = state_q;
endmodule

// File: tb/tb_vend_txn_ctrl.sv
// Directed bench for vend_txn_ctrl with hand-computed expectations.
module tb_vend_txn_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] coin_in;
    logic       btn_l, btn_r, btn_c, btn_refund, vend_ready, change_ready;
    logic [6:0] credit, sel_price, change_amt;
    logic [2:0] sel_idx, vend_item;
    logic [4:0] avail;
    logic       vend_valid, change_valid, coin_reject, deny;
    logic [1:0] state_o;

    int vectors = 0;
    int errs    = 0;

    vend_txn_ctrl #(.CREDIT_W(7), .MAX_CREDIT(99), .N_ITEMS(5),
                    .PRICE0(7), .PRICE1(5), .PRICE2(6), .PRICE3(10), .PRICE4(8),
                    .TIMEOUT_CYC(16)) dut (
        .clk(clk), .rst(rst), .coin_in(coin_in),
        .btn_l(btn_l), .btn_r(btn_r), .btn_c(btn_c), .btn_refund(btn_refund),
        .vend_ready(vend_ready), .change_ready(change_ready),
        .credit(credit), .sel_idx(sel_idx), .sel_price(sel_price), .avail(avail),
        .vend_valid(vend_valid), .vend_item(vend_item),
        .change_valid(change_valid), .change_amt(change_amt),
        .coin_reject(coin_reject), .deny(deny), .state_o(state_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive a coin level for one cycle, then release it for one cycle.
    task automatic coin(input logic [3:0] c);
        coin_in = c; tick();
        coin_in = 4'd0; tick();
    endtask

    initial begin
        rst = 1'b0; coin_in = 4'd0;
        btn_l = 0; btn_r = 0; btn_c = 0; btn_refund = 0; vend_ready = 0; change_ready = 0;
        tick(); tick();
        chk("rst_state", state_o, 0);
        chk("rst_credit", credit, 0);
        chk("rst_avail", avail, 0);
        chk("rst_vv", vend_valid, 0);
        chk("rst_cv", change_valid, 0);
        chk("rst_sel", sel_idx, 0);
        chk("rst_price", sel_price, 7);
        rst = 1'b1; tick();

        // 10-unit coin: credit next cycle, avail one cycle later
        coin_in = 4'b0100; tick();
        chk("c10_credit", credit, 10);
        chk("c10_state", state_o, 1);
        chk("c10_avail_lag", avail, 0);
        coin_in = 4'd0; tick();
        chk("c10_avail", avail, 5'b11111);

        // cursor to item 2, buy it
        btn_r = 1; tick(); chk("sel_r1", sel_idx, 1);
        btn_r = 0; tick();
        btn_r = 1; tick(); chk("sel_r2", sel_idx, 2); chk("price2", sel_price, 6);
        btn_r = 0; tick();
        btn_c = 1; tick();
        chk("vend_valid", vend_valid, 1);
        chk("vend_item", vend_item, 2);
        chk("vend_credit", credit, 4);
        chk("vend_state", state_o, 2);
        btn_c = 0;
        coin_in = 4'b0001; btn_r = 1; tick();
        chk("vend_hold1_vv", vend_valid, 1);
        chk("vend_coin_rej", coin_reject, 1);
        chk("vend_btn_ign", sel_idx, 2);
        coin_in = 4'd0; btn_r = 0; tick();
        chk("vend_hold2_vv", vend_valid, 1);
        chk("vend_hold2_cr", credit, 4);
        tick();
        chk("vend_hold3_vv", vend_valid, 1);
        chk("vend_hold3_it", vend_item, 2);
        vend_ready = 1; tick();
        chk("chg_state", state_o, 3);
        chk("chg_valid", change_valid, 1);
        chk("chg_amt", change_amt, 4);
        chk("vend_done", vend_valid, 0);
        vend_ready = 0; tick();
        chk("chg_hold", change_valid, 1);
        change_ready = 1; tick();
        chk("chg_credit0", credit, 0);
        chk("chg_idle", state_o, 0);
        chk("chg_cv0", change_valid, 0);
        change_ready = 0;

        // credit 5, cursor back to 0 with wraps, deny
        coin(4'b0010);
        chk("c5_credit", credit, 5);
        btn_l = 1; tick(); chk("sel_l1", sel_idx, 1); btn_l = 0; tick();
        btn_l = 1; tick(); chk("sel_l0", sel_idx, 0); btn_l = 0; tick();
        btn_l = 1; tick(); chk("sel_wrap_l", sel_idx, 4); btn_l = 0; tick();
        btn_r = 1; tick(); chk("sel_wrap_r", sel_idx, 0); btn_r = 0; tick();
        btn_l = 1; btn_r = 1; tick(); chk("sel_both", sel_idx, 0);
        btn_l = 0; btn_r = 0; tick();
        btn_c = 1; tick();
        chk("deny_pulse", deny, 1);
        chk("deny_credit", credit, 5);
        chk("deny_state", state_o, 1);
        btn_c = 0; tick();
        chk("deny_once", deny, 0);

        // build to 90, then overflow and multi-coin rejects
        coin(4'b1000); coin(4'b1000); coin(4'b1000); coin(4'b1000);
        chk("c85_credit", credit, 85);
        coin(4'b0010);
        chk("c90_credit", credit, 90);
        coin_in = 4'b1000; tick();
        chk("ovf_rej", coin_reject, 1);
        chk("ovf_credit", credit, 90);
        coin_in = 4'd0; tick();
        chk("rej_once", coin_reject, 0);
        coin_in = 4'b0011; tick();
        chk("multi_rej", coin_reject, 1);
        chk("multi_credit", credit, 90);
        coin_in = 4'd0; tick();
        btn_refund = 1; tick();
        chk("ref90_amt", change_amt, 90);
        btn_refund = 0; change_ready = 1; tick();
        chk("ref90_idle", state_o, 0);
        change_ready = 0;

        // credit 6, refund and confirm together -> refund wins
        coin(4'b0010); coin(4'b0001);
        chk("c6_credit", credit, 6);
        btn_refund = 1; btn_c = 1; tick();
        chk("pri_state", state_o, 3);
        chk("pri_amt", change_amt, 6);
        chk("pri_novend", vend_valid, 0);
        btn_refund = 0; btn_c = 0; change_ready = 1; tick();
        change_ready = 0;

        // timeout: 16 idle cycles in CREDIT
        coin_in = 4'b0001; tick();
        chk("to_credit", credit, 1);
        coin_in = 4'd0;
        repeat (15) tick();
        chk("to_not_yet", state_o, 1);
        tick();
        chk("to_cv", change_valid, 1);
        chk("to_amt", change_amt, 1);
        change_ready = 1; tick();
        change_ready = 0;

        // reset while in VEND
        coin(4'b0100);
        btn_r = 1; tick(); btn_r = 0; tick();
        btn_c = 1; tick(); btn_c = 0;
        chk("v1_item", vend_item, 1);
        chk("v1_credit", credit, 5);
        rst = 1'b0; tick();
        chk("r_state", state_o, 0);
        chk("r_credit", credit, 0);
        chk("r_sel", sel_idx, 0);
        chk("r_avail", avail, 0);
        chk("r_vv", vend_valid, 0);
        chk("r_item", vend_item, 0);
        chk("r_cv", change_valid, 0);
        chk("r_amt", change_amt, 0);
        chk("r_rej", coin_reject, 0);
        chk("r_deny", deny, 0);
        rst = 1'b1; tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule

// File: doc/vend_txn_ctrl.md
Name: vend_txn_ctrl

Overview:
Transaction sequencer for the vending machine datapath. It turns coin-switch and push-button levels into single-cycle events and keeps the credit register. It walks the item selection cursor and issues vend and change-return requests to the dispenser over valid/ready handshakes. It sits between the board I/O and the credit/selection datapath that drives the seven-segment and LED displays.

Parameters:
CREDIT_W, 7, credit/price width in bits
MAX_CREDIT, 99, saturation ceiling for credit
N_ITEMS, 5, number of selectable items (cursor range 0..N_ITEMS-1)
PRICE0..PRICE4, 7/5/6/10/8, item prices, all less than or equal to MAX_CREDIT
TIMEOUT_CYC, 1_000_000, idle cycles in CREDIT before automatic refund

Ports:
clk  in  1  clock
rst  in  1  synchronous, active-low reset
coin_in  in  4  coin levels; bit0=1, bit1=5, bit2=10, bit3=20 units
btn_l  in  1  cursor left (level, pre-synchronised)
btn_r  in  1  cursor right (level)
btn_c  in  1  confirm purchase (level)
btn_refund  in  1  cancel/refund (level)
vend_ready  in  1  dispenser accepts vend request
change_ready  in  1  payout unit accepts change request
credit  out  CREDIT_W  current credit
sel_idx  out  3  selection cursor
sel_price  out  CREDIT_W  price of sel_idx (combinational from sel_idx)
avail  out  N_ITEMS  avail[i]=1 iff credit >= PRICEi (registered)
vend_valid  out  1  vend request
vend_item  out  3  item being vended
change_valid  out  1  change request
change_amt  out  CREDIT_W  change amount
coin_reject  out  1  one-cycle pulse: coin event refused
deny  out  1  one-cycle pulse: confirm with insufficient credit
state_o  out  2  current FSM state (debug)

Behaviour:
- Reset (rst==0 at posedge clk): state=IDLE, credit=0, sel_idx=0, avail=0, vend_valid=0, vend_item=0, change_valid=0, change_amt=0, coin_reject=0, deny=0, timeout counter=0, all edge-detect history registers=0. Any handshake in flight is dropped.
- Edge detection: an event is input high now and low in the previous cycle. Only events act; held levels do nothing.
- Coin event (IDLE/CREDIT):
  - Exactly one coin bit rising: credit += denomination, registered, visible the next cycle.
  - If the sum would exceed MAX_CREDIT: credit unchanged, coin_reject pulses.
  - Two or more coin bits rising in the same cycle: all rejected, coin_reject pulses.
  - Coin events in VEND/CHANGE: rejected, coin_reject pulses.
- States:
  - IDLE: credit==0. A valid coin goes to CREDIT.
  - CREDIT:
    - btn_l event alone: sel_idx decrements, wrapping 0 -> N_ITEMS-1.
    - btn_r event alone: sel_idx increments, wrapping N_ITEMS-1 -> 0.
    - btn_l and btn_r events in the same cycle: ignored.
    - btn_c event with credit >= sel_price: credit -= sel_price, vend_item=sel_idx, vend_valid=1, go to VEND.
    - btn_c event with credit < sel_price: deny pulses, stay.
    - btn_refund event, or the timeout counter reaching TIMEOUT_CYC-1: change_amt=credit, change_valid=1, go to CHANGE.
    - Priority when events coincide: refund > confirm > coin > cursor. Lower-priority events in that cycle are discarded; a discarded coin event pulses coin_reject.
    - Timeout counter clears on any accepted event or on entering CREDIT.
  - VEND:
    - vend_valid and vend_item hold stable until vend_valid&&vend_ready. That transfer happens in the same cycle vend_ready is seen, including a cycle when vend_ready was already high.
    - After the handshake: credit>0 -> change_amt=credit, change_valid=1, go to CHANGE; credit==0 -> go to IDLE.
    - Buttons are ignored.
  - CHANGE:
    - change_valid and change_amt hold until change_valid&&change_ready.
    - Then credit=0, change_valid=0, go to IDLE.
    - Buttons are ignored.
- avail is recomputed every cycle from registered credit, so it lags credit by one cycle.
- sel_idx persists across transactions; it is reset only by rst.
- Arithmetic is unsigned CREDIT_W-bit. Subtraction only occurs when credit >= price, so there is no underflow.

Decomposition:
- Package vend_pkg:
  - state enum {IDLE, CREDIT, VEND, CHANGE}
  - coin denomination constants (1, 5, 10, 20)
  - price lookup function indexed by item
  - CREDIT_W default
- Sub-module rise_edge: a 1-bit registered edge detector with synchronous active-low reset, instantiated once per button input and once per coin bit.

Test Plan:
- Reset then coin_in bit2 rising -> credit=10 next cycle, state CREDIT, avail=5'b11111 one cycle later.
- credit=10, btn_r event twice (sel_idx 0->2), btn_c event -> vend_valid=1, vend_item=2, credit=4. Hold vend_ready=0 for 3 cycles, outputs stable. vend_ready=1 -> CHANGE with change_amt=4. change_ready=1 -> credit=0, IDLE.
- credit=5, sel_idx=0 (price 7), btn_c event -> deny one-cycle pulse, credit stays 5, state CREDIT.
- credit=90, coin 20 event -> coin_reject pulse, credit stays 90. bit0 and bit1 rising together -> coin_reject, credit unchanged.
- credit=6, btn_refund and btn_c events in the same cycle -> CHANGE with change_amt=6, no vend_valid.
- TIMEOUT_CYC=16, credit=1, no activity for 16 cycles -> change_valid=1, change_amt=1. Separately, assert rst in VEND -> all outputs return to reset values next cycle.
